// File: rtl/spi_master_mode0.sv
// SPI mode 0 master: one fixed-length {rw, addr, data} frame per start request,
// MSB-first, with the slave's reply captured from MISO in the same bit slots.
module spi_master_mode0 #(
  parameter int ADDR_BITS  = 7,
  parameter int DATA_BITS  = 8,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_BITS-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_BITS-1:0]  rdata,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  ss_n,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] rx_frame_q, rx_frame_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;
  logic                  sclk_q, sclk_d;
  logic                  ss_n_q, ss_n_d;
  logic                  done_q, done_d;
  logic                  expire;

  // Every non-idle state lasts exactly CLK_DIV cycles.
  assign expire = (cnt_q == DIV_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = expire ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_frame_d = rx_frame_q;
    rdata_d    = rdata_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = {rw, addr, (rw ? wdata : {DATA_BITS{1'b0}})};
          rx_d    = '0;
          bit_d   = '0;
          ss_n_d  = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (expire) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[FRAME_BITS-2:0], miso};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (expire) begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        if (expire) begin
          ss_n_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (expire) begin
          rx_frame_d = rx_q;
          rdata_d    = rx_q[DATA_BITS-1:0];
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_frame_q <= '0;
      rdata_q    <= '0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_frame_q <= rx_frame_d;
      rdata_q    <= rdata_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
    end
  end

  // MOSI is the TX register MSB, so it only moves at start and on falling SCLK.
  assign mosi     = tx_q[FRAME_BITS-1];
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rx_frame = rx_frame_q;
  assign ss_n     = ss_n_q;
  assign sclk     = sclk_q;

endmodule
